// File: rtl/genaxis_axil_pkg.sv
// -----------------------------------------------------------------------------
// genaxis_axil_pkg
//   Shared definitions for the AXI-Lite register interfaces (read and write
//   sides) of the generator control path.
//   Contents:
//     AXIL_RESP_OKAY / AXIL_RESP_SLVERR : AXI-Lite response codes
//     axil_rd_state_e                   : read-side FSM state encoding
// -----------------------------------------------------------------------------
package genaxis_axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCESS = 2'd1,
    RD_RESP   = 2'd2
  } axil_rd_state_e;

endpackage

// File: rtl/genaxis_axil_reg_if_rd.sv
// -----------------------------------------------------------------------------
// genaxis_axil_reg_if_rd
//   AXI-Lite slave, read side. Accepts one AR at a time, holds a level read
//   strobe towards the register decoder until it acks or a timeout expires,
//   then returns the captured data (OKAY) or zero data (SLVERR) on R.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid never depends on ready, and once raised the payload is
//   held stable until the transfer completes.
//
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     s_axil_ar*               AXI-Lite read address channel (arprot ignored)
//     s_axil_r*                AXI-Lite read data channel
//     reg_rd_addr / reg_rd_en  register read request (held for the access)
//     reg_rd_data / reg_rd_ack register read completion
//     reg_rd_wait              freezes the timeout counter
// -----------------------------------------------------------------------------
module genaxis_axil_reg_if_rd
  import genaxis_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  axil_rd_state_e        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rvalid_q, rvalid_d;

  // Protection bits carry no meaning for this register space.
  logic unused_arprot;
  assign unused_arprot = ^s_axil_arprot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      RD_IDLE: begin
        if (s_axil_arvalid) begin
          addr_d  = s_axil_araddr;
          cnt_d   = CNT_LOAD;
          state_d = RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        // Ack is checked first so a late ack on the final cycle still wins.
        if (reg_rd_ack) begin
          rdata_d = reg_rd_data;
          rresp_d = AXIL_RESP_OKAY;
          state_d = RD_RESP;
        end else if (cnt_q == '0) begin
          rdata_d = '0;
          rresp_d = AXIL_RESP_SLVERR;
          state_d = RD_RESP;
        end else if (!reg_rd_wait) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RD_RESP: begin
        if (s_axil_rready) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    // Strobe and valid are registered copies of the next state so they are
    // glitch-free and drop together with the state on reset.
    rd_en_d  = (state_d == RD_ACCESS);
    rvalid_d = (state_d == RD_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RD_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= AXIL_RESP_OKAY;
      rd_en_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rd_en_q  <= rd_en_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign s_axil_arready = (state_q == RD_IDLE);
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_rd_en      = rd_en_q;
  assign reg_rd_addr    = addr_q;

endmodule

// File: tb/tb_genaxis_axil_reg_if_rd.sv
// -----------------------------------------------------------------------------
// tb_genaxis_axil_reg_if_rd
//   Directed bench for the AXI-Lite read-side register interface. Expected R
//   beats are queued by the stimulus; a monitor pops and compares them as the
//   DUT completes R handshakes.
// -----------------------------------------------------------------------------
module tb_genaxis_axil_reg_if_rd;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;
  localparam int W  = DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] s_axil_araddr = '0;
  logic [2:0]    s_axil_arprot = '0;
  logic          s_axil_arvalid = 1'b0;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready = 1'b1;
  logic [AW-1:0] reg_rd_addr;
  logic          reg_rd_en;
  logic [DW-1:0] reg_rd_data = '0;
  logic          reg_rd_wait = 1'b0;
  logic          reg_rd_ack = 1'b0;

  genaxis_axil_reg_if_rd #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_wait(reg_rd_wait),
    .reg_rd_ack(reg_rd_ack)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] beat(input logic [1:0] resp, input logic [DW-1:0] data);
    return {resp, data};
  endfunction

  // Monitor: inputs change just after posedge, so a negedge sample with
  // rvalid && rready means the handshake lands on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && s_axil_rvalid && s_axil_rready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_unexpected: got beat resp=%0h data=0x%0h expected none at %0t",
                 s_axil_rresp, s_axil_rdata, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("r_data", 64'(s_axil_rdata), 64'(e[DW-1:0]));
        chk("r_resp", 64'(s_axil_rresp), 64'(e[W-1:DW]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one AR (DUT must be idle) and checks the strobe the next cycle.
  task automatic do_ar(input logic [AW-1:0] addr);
    chk("ar_ready_before", 64'(s_axil_arready), 64'd1);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    chk("rd_en_after_ar", 64'(reg_rd_en), 64'd1);
    chk("rd_addr_after_ar", 64'(reg_rd_addr), 64'(addr));
  endtask

  // Counts remaining ACCESS cycles (strobe high), driving wait for the first
  // wait_cycles of them. Bounded so a stuck DUT cannot hang the run.
  task automatic count_access(input int wait_cycles, output int n);
    n = 0;
    while (reg_rd_en && n < 50) begin
      reg_rd_wait = (n < wait_cycles);
      n++;
      tick();
    end
    reg_rd_wait = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---------------- reset ----------------
    #12;
    chk("rst_arready", 64'(s_axil_arready), 64'd1);
    chk("rst_rvalid", 64'(s_axil_rvalid), 64'd0);
    chk("rst_rdata", 64'(s_axil_rdata), 64'd0);
    chk("rst_rresp", 64'(s_axil_rresp), 64'd0);
    chk("rst_rd_en", 64'(reg_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(reg_rd_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- single read, immediate ack ----------------
    do_ar(32'h10);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'hDEADBEEF;
    exp_q.push_back(beat(2'b00, 32'hDEADBEEF));
    tick();
    reg_rd_ack = 1'b0;
    chk("t1_rvalid", 64'(s_axil_rvalid), 64'd1);
    chk("t1_rd_en_low", 64'(reg_rd_en), 64'd0);
    tick();
    chk("t1_arready_back", 64'(s_axil_arready), 64'd1);
    chk("t1_rvalid_low", 64'(s_axil_rvalid), 64'd0);

    // ---------------- timeout ----------------
    do_ar(32'h24);
    exp_q.push_back(beat(2'b10, 32'h0));
    count_access(0, n);
    chk("to_access_cycles", 64'(n), 64'(TO));
    chk("to_rvalid", 64'(s_axil_rvalid), 64'd1);
    tick();

    // ---------------- wait extends timeout ----------------
    do_ar(32'h28);
    exp_q.push_back(beat(2'b10, 32'h0));
    count_access(3, n);
    chk("wait_access_cycles", 64'(n), 64'(TO + 3));
    chk("wait_rvalid", 64'(s_axil_rvalid), 64'd1);
    tick();

    // ---------------- R back-pressure ----------------
    s_axil_rready = 1'b0;
    do_ar(32'h30);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'h12345678;
    exp_q.push_back(beat(2'b00, 32'h12345678));
    tick();
    reg_rd_ack  = 1'b0;
    reg_rd_data = 32'hFFFF0000;
    s_axil_araddr  = 32'h20;
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 64'(s_axil_rvalid), 64'd1);
      chk("bp_rdata", 64'(s_axil_rdata), 64'h12345678);
      chk("bp_rresp", 64'(s_axil_rresp), 64'd0);
      chk("bp_arready", 64'(s_axil_arready), 64'd0);
      chk("bp_rd_en", 64'(reg_rd_en), 64'd0);
      tick();
    end
    s_axil_rready = 1'b1;
    tick();
    chk("bp_arready_after", 64'(s_axil_arready), 64'd1);
    chk("bp_no_early_ar", 64'(reg_rd_en), 64'd0);
    tick();
    s_axil_arvalid = 1'b0;
    chk("bp_second_rd_en", 64'(reg_rd_en), 64'd1);
    chk("bp_second_addr", 64'(reg_rd_addr), 64'h20);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'h0000A5A5;
    exp_q.push_back(beat(2'b00, 32'h0000A5A5));
    tick();
    reg_rd_ack = 1'b0;
    tick();

    // ---------------- ack on the final ACCESS cycle ----------------
    do_ar(32'h34);
    tick();
    tick();
    tick();
    chk("last_rd_en", 64'(reg_rd_en), 64'd1);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'hCAFEF00D;
    exp_q.push_back(beat(2'b00, 32'hCAFEF00D));
    tick();
    reg_rd_ack = 1'b0;
    chk("last_rvalid", 64'(s_axil_rvalid), 64'd1);
    tick();

    // ---------------- async reset during ACCESS ----------------
    do_ar(32'h44);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstA_rd_en", 64'(reg_rd_en), 64'd0);
    chk("rstA_rd_addr", 64'(reg_rd_addr), 64'd0);
    chk("rstA_rvalid", 64'(s_axil_rvalid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- async reset during RESP ----------------
    s_axil_rready = 1'b0;
    do_ar(32'h48);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'h55AA55AA;
    tick();
    reg_rd_ack = 1'b0;
    chk("rstR_rvalid_before", 64'(s_axil_rvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstR_rvalid", 64'(s_axil_rvalid), 64'd0);
    chk("rstR_rd_en", 64'(reg_rd_en), 64'd0);
    chk("rstR_rd_addr", 64'(reg_rd_addr), 64'd0);
    chk("rstR_arready", 64'(s_axil_arready), 64'd1);
    tick();
    rst_n = 1'b1;
    s_axil_rready = 1'b1;
    tick();

    // ---------------- fresh read after reset ----------------
    do_ar(32'h4C);
    tick();
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'h0BADF00D;
    exp_q.push_back(beat(2'b00, 32'h0BADF00D));
    tick();
    reg_rd_ack = 1'b0;
    chk("fresh_rvalid", 64'(s_axil_rvalid), 64'd1);
    tick();
    tick();

    // ---------------- report ----------------
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
